// File: rtl/muldiv_unit.sv
// HI/LO owner for the core: runs a fixed-length busy window per MULT/DIV command
// and commits the 64-bit result to HI/LO in one step at the end of that window.
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  op,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int DATA_W = 32;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic [DATA_W-1:0]   opa, opb;
  logic [2:0]          kind;
  logic                issue;
  logic [2*DATA_W-1:0] res;
  logic                res_ok;

  // Low 64 bits of the product of the sign- or zero-extended operands.
  function automatic logic [2*DATA_W-1:0] mul64(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic              sgn);
    logic [2*DATA_W-1:0] ea, eb;
    ea = sgn ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
    eb = sgn ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
    return ea * eb;
  endfunction

  // Returns {ok, remainder, quotient}; signed results come from magnitudes so that
  // MIN / -1 wraps to MIN with a zero remainder instead of overflowing.
  function automatic logic [2*DATA_W:0] div64(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic              sgn);
    logic              neg_a, neg_b;
    logic [DATA_W-1:0] ua, ub, q, r;
    neg_a = sgn & a[DATA_W-1];
    neg_b = sgn & b[DATA_W-1];
    ua = neg_a ? -a : a;
    ub = neg_b ? -b : b;
    if (b == '0) return '0;
    q = ua / ub;
    r = ua % ub;
    if (neg_a ^ neg_b) q = -q;
    if (neg_a) r = -r;
    return {1'b1, r, q};
  endfunction

  assign issue = (op >= OP_MULT) && (op <= OP_DIVU);
  assign busy  = (state == BUSY) || issue;

  always_comb begin
    logic [2*DATA_W:0] d;
    res    = '0;
    res_ok = 1'b1;
    d      = '0;
    if (kind == OP_MULT || kind == OP_MULTU) begin
      res = mul64(opa, opb, kind == OP_MULT);
    end else begin
      d      = div64(opa, opb, kind == OP_DIV);
      res    = d[2*DATA_W-1:0];
      res_ok = d[2*DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            state <= BUSY;
            cnt   <= (op == OP_MULT || op == OP_MULTU) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
          end else if (op == OP_MTHI) begin
            hi <= src0;
          end else if (op == OP_MTLO) begin
            lo <= src0;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= IDLE;
            if (res_ok) {hi, lo} <= res;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture only happens on an accepted issue, so later src changes are inert.
  always_ff @(posedge clk) begin
    if (state == IDLE && issue) begin
      opa  <= src0;
      opb  <= src1;
      kind <= op;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed scenarios with literal expectations, then random
// traffic, all compared each cycle against a cycle-indexed behavioural model.
module tb_muldiv_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  op;
  logic [31:0] src0, src1;
  logic        busy;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // model state: architectural values plus the pending result and its commit edge
  logic [31:0] m_hi, m_lo, m_rhi, m_rlo;
  bit          m_inflight, m_ok;
  int          p, done_at;

  muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .op(op), .src0(src0), .src1(src1),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, p);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, busy}, {31'd0, m_inflight || (op >= 3'd1 && op <= 3'd4)});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  task automatic model_edge(input logic r, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, rm;
    logic [63:0] prod;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (r) begin
      m_hi = 0; m_lo = 0; m_inflight = 0;
    end else if (m_inflight) begin
      if (p == done_at) begin
        m_inflight = 0;
        if (m_ok) begin m_hi = m_rhi; m_lo = m_rlo; end
      end
    end else if (o >= 3'd1 && o <= 3'd4) begin
      m_inflight = 1;
      done_at = p + ((o <= 3'd2) ? MC : DC);
      m_ok = 1;
      case (o)
        3'd1: begin prod = sa * sb; {m_rhi, m_rlo} = prod; end
        3'd2: begin prod = {32'd0, a} * {32'd0, b}; {m_rhi, m_rlo} = prod; end
        3'd3: begin
          if (b == 0) m_ok = 0;
          else begin
            q = sa / sb; rm = sa % sb;
            m_rlo = q[31:0]; m_rhi = rm[31:0];
          end
        end
        default: begin
          if (b == 0) m_ok = 0;
          else begin m_rlo = a / b; m_rhi = a % b; end
        end
      endcase
    end else if (o == 3'd5) begin
      m_hi = a;
    end else if (o == 3'd6) begin
      m_lo = a;
    end
    p++;
  endtask

  task automatic step(input logic r, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    reset = r; op = o; src0 = a; src1 = b;
    @(posedge clk);
    model_edge(r, o, a, b);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, $urandom, $urandom);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] c [6];
    c = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};
    if ($urandom_range(0, 2) == 0) return c[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    p = 0; done_at = 0; m_inflight = 0; m_ok = 0;
    m_hi = 0; m_lo = 0; m_rhi = 0; m_rlo = 0;
    step(1'b1, 3'd0, 0, 0);
    chk_en = 1;

    // 1: reset state
    step(1'b0, 3'd0, 0, 0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // 2: MULT -3 * 5, old values visible until the window closes
    step(1'b0, 3'd1, 32'hFFFFFFFD, 32'd5);
    idle(4);
    check("mult_busy_mid", {31'd0, busy}, 32'd1);
    check("mult_hi_old", hi, 32'h0);
    idle(1);
    check("mult_busy_end", {31'd0, busy}, 32'd0);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFF1);

    // 3: MULTU, DIV, DIVU
    step(1'b0, 3'd2, 32'hFFFFFFFF, 32'd2); idle(MC);
    check("multu_hi", hi, 32'h1);
    check("multu_lo", lo, 32'hFFFFFFFE);
    step(1'b0, 3'd3, 32'hFFFFFFF9, 32'd2); idle(DC);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    step(1'b0, 3'd4, 32'd7, 32'd2); idle(DC);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);
    step(1'b0, 3'd3, 32'h80000000, 32'hFFFFFFFF); idle(DC);
    check("divmin_lo", lo, 32'h80000000);
    check("divmin_hi", hi, 32'h0);

    // 4: divide by zero keeps HI/LO; MTHI
    step(1'b0, 3'd5, 32'h11, 0);
    step(1'b0, 3'd6, 32'h22, 0);
    step(1'b0, 3'd3, 32'h1234, 32'd0); idle(DC - 1);
    check("div0_busy", {31'd0, busy}, 32'd1);
    idle(1);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);
    step(1'b0, 3'd5, 32'hABCD, 0);
    check("mthi_hi", hi, 32'hABCD);
    idle(1);
    check("mthi_busy", {31'd0, busy}, 32'd0);

    // 5: commands while busy are ignored; operand changes are inert
    step(1'b0, 3'd1, 32'd6, 32'd7);
    step(1'b0, 3'd6, 32'h55, 0);
    step(1'b0, 3'd4, 32'd100, 32'd3);
    step(1'b0, 3'd0, 32'hDEADBEEF, 32'h0);
    idle(2);
    check("ign_hi", hi, 32'h0);
    check("ign_lo", lo, 32'd42);
    idle(2);
    check("ign_idle", {31'd0, busy}, 32'd0);

    // 6: reset aborts a DIV; MULT with reset is dropped
    step(1'b0, 3'd3, 32'd50, 32'd7); idle(3);
    step(1'b1, 3'd0, 0, 0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    step(1'b1, 3'd1, 32'd3, 32'd3);
    step(1'b0, 3'd0, 0, 0);
    check("rstmult_busy", {31'd0, busy}, 32'd0);
    idle(MC);
    check("rstmult_lo", lo, 32'h0);

    // random traffic, including commands during busy and occasional reset
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] o;
      o = (($urandom_range(0, 2)) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      step($urandom_range(0, 199) == 0, o, pick(), pick());
    end
    idle(DC + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
